// File: rtl/noc_rr_timeout_arbiter.sv
// noc_rr_timeout_arbiter: round-robin output-port arbiter with per-input packet-length hold limit and timeout pulse
module noc_rr_timeout_arbiter #(
   parameter int NUM_PORTS = 5,
   parameter int LEN_W = 12,
   parameter int FID_W = 3,
   parameter int HEADER_ID = 1,
   localparam int ID_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0]       req,
   input  logic [NUM_PORTS*FID_W-1:0] flit_id,
   input  logic [NUM_PORTS*LEN_W-1:0] length,
   output logic [NUM_PORTS-1:0]       grant,
   output logic                       grant_valid,
   output logic [ID_W-1:0]            grant_id,
   output logic [NUM_PORTS-1:0]       timeout
);
   localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};
   logic [LEN_W-1:0] limit [NUM_PORTS];
   logic [LEN_W-1:0] count, lim_g;
   logic [ID_W-1:0] ptr, sel;
   logic [NUM_PORTS-1:0] cand;
   logic found, expire, hold;
   assign lim_g = limit[grant_id];
   assign expire = grant_valid && lim_g != '0 && count >= lim_g - LEN_W'(1);
   assign hold = grant_valid && req[grant_id] && !expire;
   // an expiring holder sits out the search for one cycle
   assign cand = req & ~(expire ? grant : '0);
   always_comb begin
      found = 1'b0;
      sel = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         if (!found && cand[(int'(ptr) + i) % NUM_PORTS]) begin
            found = 1'b1;
            sel = ID_W'((int'(ptr) + i) % NUM_PORTS);
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < NUM_PORTS; p++) limit[p] <= '0;
         grant <= '0;
         grant_valid <= 1'b0;
         grant_id <= '0;
         timeout <= '0;
         count <= '0;
         ptr <= ID_W'(NUM_PORTS - 1);
      end else begin
         for (int p = 0; p < NUM_PORTS; p++)
            if (flit_id[p*FID_W +: FID_W] == FID_W'(HEADER_ID)) limit[p] <= length[p*LEN_W +: LEN_W];
         timeout <= (expire && req[grant_id]) ? grant : '0;
         if (hold) begin
            count <= &count ? count : count + LEN_W'(1);
         end else if (found) begin
            grant <= ONE << sel;
            grant_valid <= 1'b1;
            grant_id <= sel;
            count <= '0;
            ptr <= sel;
         end else begin
            grant <= '0;
            grant_valid <= 1'b0;
            grant_id <= '0;
            count <= '0;
         end
      end
   end
endmodule

// File: tb/tb_noc_rr_timeout_arbiter.sv
// tb_noc_rr_timeout_arbiter: directed and random checks of the arbiter against a cycle-level holder/rotation model
module tb_noc_rr_timeout_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic [4:0] req;
   logic [14:0] flit_id;
   logic [59:0] length;
   logic [4:0] grant;
   logic grant_valid;
   logic [2:0] grant_id;
   logic [4:0] timeout;
   int total = 0;
   int bad = 0;
   // model: current holder (-1 idle), cycles it has held including this one, last granted port
   int m_hold, m_held, m_ptr;
   int m_lim [5];
   logic [4:0] m_to;
   logic [4:0] to_seen;

   noc_rr_timeout_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
      .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hold = -1;
      m_held = 0;
      m_ptr = 4;
      m_to = '0;
      for (int p = 0; p < 5; p++) m_lim[p] = 0;
   endtask

   task automatic model_step();
      int nh, nheld;
      bit ex;
      nh = -1;
      nheld = 0;
      ex = 0;
      m_to = '0;
      if (m_hold >= 0) begin
         ex = m_lim[m_hold] != 0 && m_held >= m_lim[m_hold];
         if (req[m_hold] && !ex) begin
            nh = m_hold;
            nheld = m_held + 1;
         end else if (ex && req[m_hold]) m_to[m_hold] = 1'b1;
      end
      if (nh < 0)
         for (int k = 1; k <= 5; k++) begin
            int p = (m_ptr + k) % 5;
            if (nh < 0 && req[p] && !(ex && p == m_hold)) begin
               nh = p;
               nheld = 1;
               m_ptr = p;
            end
         end
      m_hold = nh;
      m_held = nheld;
      for (int p = 0; p < 5; p++)
         if (flit_id[p*3 +: 3] == 3'd1) m_lim[p] = int'(length[p*12 +: 12]);
   endtask

   task automatic check_all();
      chk("grant", grant, m_hold < 0 ? 0 : 32'(1) << m_hold);
      chk("grant_id", grant_id, m_hold < 0 ? 0 : m_hold);
      chk("grant_valid", grant_valid, m_hold >= 0);
      chk("timeout", timeout, m_to);
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      to_seen |= timeout;
   endtask

   task automatic header(input int p, input int len);
      flit_id[p*3 +: 3] = 3'd1;
      length[p*12 +: 12] = 12'(len);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0;
      flit_id = '0;
      length = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("rst_grant", grant, 0);
      chk("rst_valid", grant_valid, 0);
      chk("rst_timeout", timeout, 0);
   endtask

   initial begin
      do_reset();
      // T1: limit 3 on port 0
      header(0, 3);
      cyc();
      flit_id = '0;
      req = 5'b00001;
      cyc(); chk("t1_c1", grant, 5'b00001);
      cyc(); chk("t1_c2", grant, 5'b00001);
      cyc(); chk("t1_c3", grant, 5'b00001);
      cyc(); chk("t1_c4_idle", grant, 5'b00000); chk("t1_c4_to", timeout, 5'b00001);
      cyc(); chk("t1_c5", grant, 5'b00001);
      // T2: all limits 1, full rotation
      do_reset();
      for (int p = 0; p < 5; p++) header(p, 1);
      cyc();
      flit_id = '0;
      req = 5'b11111;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("t2_id", grant_id, i % 5);
         if (i > 0) chk("t2_to", timeout, 5'b00001 << ((i + 4) % 5));
      end
      // T3: unlimited hold
      do_reset();
      header(2, 0);
      req = 5'b00100;
      to_seen = '0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         flit_id = '0;
      end
      chk("t3_grant", grant, 5'b00100);
      chk("t3_no_timeout", to_seen, 0);
      // T4: holder drops request
      do_reset();
      header(1, 8);
      cyc();
      flit_id = '0;
      req = 5'b00010;
      cyc(); cyc();
      chk("t4_hold", grant, 5'b00010);
      req = 5'b01000;
      cyc(); chk("t4_move", grant, 5'b01000); chk("t4_to", timeout, 0);
      // T6: limit shrunk below count
      do_reset();
      header(0, 8);
      cyc();
      flit_id = '0;
      req = 5'b00101;
      repeat (6) cyc();
      header(0, 3);
      cyc(); chk("t6_still", grant, 5'b00001);
      flit_id = '0;
      cyc(); chk("t6_move", grant, 5'b00100); chk("t6_to", timeout, 5'b00001);
      // T5: asynchronous reset mid-packet
      do_reset();
      header(4, 2);
      cyc();
      flit_id = '0;
      header(0, 0);
      req = 5'b10000;
      cyc(); flit_id = '0;
      chk("t5_hold", grant, 5'b10000);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("t5_grant", grant, 0);
      chk("t5_valid", grant_valid, 0);
      chk("t5_id", grant_id, 0);
      chk("t5_to", timeout, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 5'b10001;
      cyc(); chk("t5_first", grant, 5'b00001);
      req = 5'b10000;
      repeat (6) cyc();
      chk("t5_nolimit", grant, 5'b10000);
      // random traffic
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) req = 5'($urandom_range(0, 31));
         for (int p = 0; p < 5; p++) begin
            flit_id[p*3 +: 3] = ($urandom_range(0, 5) == 0) ? 3'd1 : 3'($urandom_range(2, 7));
            length[p*12 +: 12] = 12'($urandom_range(0, 6));
         end
         cyc();
         chk("onehot", $onehot0(grant), 1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
